// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared state encoding and default constants for the step receive meter
package step_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        STALL   = 2'd3
    } step_state_e;

    localparam int STEP_SIZE_DEF     = 16;
    localparam int STEP_POS_W_DEF    = 32;
    localparam int STEP_TIMEOUT_DEF  = 100000;
    localparam int STEP_FILT_LEN_DEF = 3;

endpackage

// File: rtl/step_sync_edge.sv
// rtl/step_sync_edge.sv - step/dir synchronizer, optional glitch filter (STEP_GLITCH_FILTER_EN) and edge detector
module step_sync_edge
    import step_pkg::*;
#(
    parameter int FILT_LEN = STEP_FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic step_in,
    input  logic dir_in,
    output logic edge_stb,
    output logic dir_sync
);

`ifdef STEP_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    // Without the filter a run length of one cycle is a plain rising-edge detector.
    localparam int RUN_LEN = FILT_ON ? FILT_LEN : 1;
    localparam int CNT_W   = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);

    logic [1:0]       step_ff;
    logic [1:0]       dir_ff;
    logic [CNT_W-1:0] high_cnt;

    // two-stage synchronizer for the asynchronous step and direction lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_ff <= 2'b00;
            dir_ff  <= 2'b00;
        end else begin
            step_ff <= {step_ff[0], step_in};
            dir_ff  <= {dir_ff[0], dir_in};
        end
    end

    // count the synchronized high run; fire once when it reaches RUN_LEN cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            high_cnt <= '0;
            edge_stb <= 1'b0;
            dir_sync <= 1'b0;
        end else begin
            edge_stb <= step_ff[1] && (high_cnt == RUN_LAST);
            dir_sync <= dir_ff[1];
            if (!step_ff[1]) begin
                high_cnt <= '0;
            end else if (high_cnt != RUN_MAX) begin
                high_cnt <= high_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_rx_meter.sv
// rtl/step_rx_meter.sv - step pulse interval meter with position counter and stall detect (STEP_GLITCH_FILTER_EN adds input filter)
module step_rx_meter
    import step_pkg::*;
#(
    parameter int SIZE     = STEP_SIZE_DEF,
    parameter int POS_W    = STEP_POS_W_DEF,
    parameter int TIMEOUT  = STEP_TIMEOUT_DEF,
    parameter int FILT_LEN = STEP_FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             enable,
    input  logic             pos_clr,
    output logic [SIZE:0]    period,
    output logic             period_valid,
    output logic [POS_W-1:0] position,
    output logic             stall
);

    localparam int CW = SIZE + 1;
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    step_state_e   state;
    logic [CW-1:0] ivl_cnt;
    logic          step_edge;
    logic          step_dir;

    step_sync_edge #(
        .FILT_LEN (FILT_LEN)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .step_in  (step_in),
        .dir_in   (dir_in),
        .edge_stb (step_edge),
        .dir_sync (step_dir)
    );

    // measurement FSM: arm on first edge, time edge-to-edge intervals, flag stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ivl_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                ivl_cnt <= '0;
                stall   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ivl_cnt <= '0;
                        state   <= ARM;
                    end
                    ARM: begin
                        if (step_edge) begin
                            state   <= MEASURE;
                            ivl_cnt <= ONE;
                        end
                    end
                    MEASURE: begin
                        // an edge landing on the timeout cycle still closes the interval
                        if (step_edge) begin
                            period       <= ivl_cnt;
                            period_valid <= 1'b1;
                            ivl_cnt      <= ONE;
                        end else if (ivl_cnt == TIMEOUT_C) begin
                            state <= STALL;
                            stall <= 1'b1;
                        end else if (ivl_cnt != CNT_MAX) begin
                            ivl_cnt <= ivl_cnt + ONE;
                        end
                    end
                    STALL: begin
                        if (step_edge) begin
                            state   <= MEASURE;
                            ivl_cnt <= ONE;
                            stall   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // signed step position; clear wins over a coincident edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            position <= '0;
        end else if (pos_clr) begin
            position <= '0;
        end else if (enable && (state != IDLE) && step_edge) begin
            position <= step_dir ? position + POS_W'(1) : position - POS_W'(1);
        end
    end

endmodule
